// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer between the pipeline and the data cache.
// It aligns store data into byte lanes, runs the request/response handshake,
// guards the response wait with a timeout, and returns sign/zero-extended
// load results. The upstream pipeline is frozen with stall while it works.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no transaction; accepts an aligned load/store, flags misalignment
// S_REQ  | request presented to the dcache, held stable until ready
// S_WAIT | load issued, waiting for the response strobe (timeout counted)
// S_DONE | transaction finished; load result pulses wb_valid, stall released
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_valid,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [3:0]  write_mask,
   output logic        dcache_req_valid,
   input  logic        dcache_req_ready,
   output logic [31:0] dcache_addr,
   output logic [31:0] dcache_din,
   output logic [3:0]  dcache_we,
   output logic        dcache_re,
   input  logic        dcache_resp_valid,
   input  logic [31:0] dcache_dout,
   output logic        stall,
   output logic        wb_valid,
   output logic [31:0] load_data,
   output logic        exc_misaligned,
   output logic        exc_bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Counter runs 0..TIMEOUT_CYC-1 across the WAIT cycles; the last value
   // is the cycle in which the bus error is declared.
   localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             load_q;
   logic [2:0]       funct3_q;
   logic [1:0]       offset_q;

   logic             op_mem;
   logic             aligned;
   logic             accept;
   logic             misalign;
   logic [31:0]      lane_data;

   // Alignment: bytes always legal, halves need addr[0]=0, words need addr[1:0]=0.
   always_comb begin
      aligned = 1'b1;
      case (funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~addr[0];
         default: aligned = (addr[1:0] == 2'b00);
      endcase
   end

   assign op_mem   = mem_valid & (is_load | is_store);
   assign accept   = (state == S_IDLE) & op_mem & aligned;
   assign misalign = (state == S_IDLE) & op_mem & ~aligned;

   // Stall must rise in the accepting cycle so the op is not lost upstream.
   assign stall = accept | (state == S_REQ) | (state == S_WAIT);

   // Replicate store data so every byte lane carries the value; the write
   // mask then picks the lanes that actually get written.
   always_comb begin
      lane_data = store_data;
      case (funct3[1:0])
         2'b00:   lane_data = {4{store_data[7:0]}};
         2'b01:   lane_data = {2{store_data[15:0]}};
         default: lane_data = store_data;
      endcase
   end

   function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return word;
      endcase
   endfunction

   // Main sequencer: state, latched op, dcache request and result/fault pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         wait_cnt         <= '0;
         load_q           <= 1'b0;
         funct3_q         <= 3'd0;
         offset_q         <= 2'd0;
         dcache_req_valid <= 1'b0;
         dcache_addr      <= 32'd0;
         dcache_din       <= 32'd0;
         dcache_we        <= 4'd0;
         dcache_re        <= 1'b0;
         wb_valid         <= 1'b0;
         load_data        <= 32'd0;
         exc_misaligned   <= 1'b0;
         exc_bus          <= 1'b0;
      end else begin
         wb_valid       <= 1'b0;
         exc_misaligned <= 1'b0;
         exc_bus        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  load_q           <= is_load;
                  funct3_q         <= funct3;
                  offset_q         <= addr[1:0];
                  dcache_addr      <= {addr[31:2], 2'b00};
                  dcache_din       <= lane_data;
                  dcache_we        <= is_load ? 4'd0 : write_mask;
                  dcache_re        <= is_load;
                  dcache_req_valid <= 1'b1;
                  wait_cnt         <= '0;
                  state            <= S_REQ;
               end else if (misalign) begin
                  exc_misaligned <= 1'b1;
               end
            end
            S_REQ: begin
               if (dcache_req_ready) begin
                  dcache_req_valid <= 1'b0;
                  dcache_we        <= 4'd0;
                  dcache_re        <= 1'b0;
                  state            <= load_q ? S_WAIT : S_DONE;
               end
            end
            S_WAIT: begin
               // A response in the final timeout cycle still completes the load.
               if (dcache_resp_valid) begin
                  load_data <= extract_load(dcache_dout, offset_q, funct3_q);
                  wb_valid  <= 1'b1;
                  state     <= S_DONE;
               end else if (wait_cnt == CNT_LAST) begin
                  exc_bus  <= 1'b1;
                  wait_cnt <= '0;
                  state    <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (instantiated with TIMEOUT_CYC=4).
module tb_mem_access_unit;

   logic        clk;
   logic        reset_n;
   logic        mem_valid;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [3:0]  write_mask;
   logic        dcache_req_valid;
   logic        dcache_req_ready;
   logic [31:0] dcache_addr;
   logic [31:0] dcache_din;
   logic [3:0]  dcache_we;
   logic        dcache_re;
   logic        dcache_resp_valid;
   logic [31:0] dcache_dout;
   logic        stall;
   logic        wb_valid;
   logic [31:0] load_data;
   logic        exc_misaligned;
   logic        exc_bus;

   int errors = 0;
   int checks = 0;

   mem_access_unit #(.TIMEOUT_CYC(4)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .mem_valid         (mem_valid),
      .is_load           (is_load),
      .is_store          (is_store),
      .funct3            (funct3),
      .addr              (addr),
      .store_data        (store_data),
      .write_mask        (write_mask),
      .dcache_req_valid  (dcache_req_valid),
      .dcache_req_ready  (dcache_req_ready),
      .dcache_addr       (dcache_addr),
      .dcache_din        (dcache_din),
      .dcache_we         (dcache_we),
      .dcache_re         (dcache_re),
      .dcache_resp_valid (dcache_resp_valid),
      .dcache_dout       (dcache_dout),
      .stall             (stall),
      .wb_valid          (wb_valid),
      .load_data         (load_data),
      .exc_misaligned    (exc_misaligned),
      .exc_bus           (exc_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present_op(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      mem_valid  = 1'b1;
      is_load    = ld;
      is_store   = st;
      funct3     = f3;
      addr       = a;
      store_data = d;
      write_mask = m;
      #1;
   endtask

   task automatic clear_op();
      mem_valid = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_op();
      funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; write_mask = 4'd0;
      dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0; dcache_dout = 32'd0;
      tick(); tick();
      checks++; if (dcache_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", dcache_req_valid); end
      checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL reset_load_data: got %h want 00000000", load_data); end
      checks++; if ({stall, wb_valid, exc_misaligned, exc_bus, dcache_re} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {stall, wb_valid, exc_misaligned, exc_bus, dcache_re}); end
      checks++; if ({dcache_addr, dcache_din, dcache_we} !== 68'd0) begin errors++; $display("FAIL reset_dcache_bus: got %h/%h/%b want zeros", dcache_addr, dcache_din, dcache_we); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_lb();
      present_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 4'd0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall_accept: got %b want 1", stall); end
      tick(); clear_op();
      checks++; if (dcache_req_valid !== 1'b1) begin errors++; $display("FAIL lb_req_valid: got %b want 1", dcache_req_valid); end
      checks++; if (dcache_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr: got %h want 00001000", dcache_addr); end
      checks++; if ({dcache_re, dcache_we} !== 5'b1_0000) begin errors++; $display("FAIL lb_re_we: got %b want 10000", {dcache_re, dcache_we}); end
      dcache_req_ready = 1'b1;
      tick(); dcache_req_ready = 1'b0;
      checks++; if ({dcache_req_valid, stall, wb_valid} !== 3'b010) begin errors++; $display("FAIL lb_wait: got %b want 010", {dcache_req_valid, stall, wb_valid}); end
      dcache_resp_valid = 1'b1; dcache_dout = 32'h80AA_5511;
      tick(); dcache_resp_valid = 1'b0; dcache_dout = 32'hDEAD_BEEF;
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lb_wb_valid: got %b want 1", wb_valid); end
      checks++; if (load_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_load_data: got %h want ffffff80", load_data); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lb_stall_done: got %b want 0", stall); end
      tick();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lb_wb_pulse_end: got %b want 0", wb_valid); end
      checks++; if (load_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_load_hold: got %h want ffffff80", load_data); end
   endtask

   task automatic test_sh();
      present_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 4'b1100);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sh_stall_accept: got %b want 1", stall); end
      tick(); clear_op();
      checks++; if (dcache_din !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_din: got %h want beefbeef", dcache_din); end
      checks++; if ({dcache_we, dcache_re} !== 5'b1100_0) begin errors++; $display("FAIL sh_we_re: got %b want 11000", {dcache_we, dcache_re}); end
      checks++; if (dcache_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr: got %h want 00002000", dcache_addr); end
      dcache_req_ready = 1'b1;
      tick(); dcache_req_ready = 1'b0;
      checks++; if ({wb_valid, stall, dcache_req_valid} !== 3'b000) begin errors++; $display("FAIL sh_done: got %b want 000", {wb_valid, stall, dcache_req_valid}); end
      tick();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL sh_no_wb: got %b want 0", wb_valid); end
      checks++; if (load_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL sh_load_hold: got %h want ffffff80", load_data); end
   endtask

   task automatic test_sb_lanes();
      present_op(1'b0, 1'b1, 3'b000, 32'h0000_2101, 32'h1234_56A7, 4'b0010);
      tick(); clear_op();
      checks++; if (dcache_din !== 32'hA7A7_A7A7) begin errors++; $display("FAIL sb_din: got %h want a7a7a7a7", dcache_din); end
      checks++; if (dcache_we !== 4'b0010) begin errors++; $display("FAIL sb_we: got %b want 0010", dcache_we); end
      dcache_req_ready = 1'b1;
      tick(); dcache_req_ready = 1'b0;
      tick();
   endtask

   task automatic test_misaligned();
      present_op(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 4'd0);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_lw_stall: got %b want 0", stall); end
      tick(); clear_op();
      checks++; if ({exc_misaligned, dcache_req_valid} !== 2'b10) begin errors++; $display("FAIL mis_lw_pulse: got %b want 10", {exc_misaligned, dcache_req_valid}); end
      tick();
      checks++; if ({exc_misaligned, dcache_req_valid, stall} !== 3'b000) begin errors++; $display("FAIL mis_lw_after: got %b want 000", {exc_misaligned, dcache_req_valid, stall}); end
      present_op(1'b0, 1'b1, 3'b001, 32'h0000_3003, 32'd0, 4'b1100);
      tick(); clear_op();
      checks++; if ({exc_misaligned, dcache_req_valid} !== 2'b10) begin errors++; $display("FAIL mis_sh_pulse: got %b want 10", {exc_misaligned, dcache_req_valid}); end
      tick();
   endtask

   task automatic test_ignore();
      present_op(1'b0, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 4'hF);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ign_stall: got %b want 0", stall); end
      tick(); clear_op();
      checks++; if ({dcache_req_valid, exc_misaligned} !== 2'b00) begin errors++; $display("FAIL ign_no_req: got %b want 00", {dcache_req_valid, exc_misaligned}); end
   endtask

   task automatic test_ready_stall();
      present_op(1'b1, 1'b0, 3'b010, 32'h0000_4008, 32'd0, 4'd0);
      tick(); clear_op();
      for (int i = 0; i < 5; i++) begin
         checks++; if ({dcache_req_valid, stall, dcache_re, dcache_addr} !== {3'b111, 32'h0000_4008}) begin errors++; $display("FAIL rdy_hold_%0d: got %b%b%b %h want 111 00004008", i, dcache_req_valid, stall, dcache_re, dcache_addr); end
         tick();
      end
      dcache_req_ready = 1'b1;
      tick(); dcache_req_ready = 1'b0;
      checks++; if ({dcache_req_valid, stall} !== 2'b01) begin errors++; $display("FAIL rdy_handshake: got %b want 01", {dcache_req_valid, stall}); end
      dcache_resp_valid = 1'b1; dcache_dout = 32'h1234_5678;
      tick(); dcache_resp_valid = 1'b0;
      checks++; if ({wb_valid, load_data} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL rdy_lw_data: got %b %h want 1 12345678", wb_valid, load_data); end
      tick();
   endtask

   // Full load with immediate ready and response; wb_valid expected exactly 3 cycles after acceptance.
   task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] dout, input logic [31:0] exp);
      present_op(1'b1, 1'b0, f3, a, 32'd0, 4'd0);
      tick(); clear_op();
      dcache_req_ready = 1'b1;
      tick(); dcache_req_ready = 1'b0;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL %s_early_wb: got %b want 0", name, wb_valid); end
      dcache_resp_valid = 1'b1; dcache_dout = dout;
      tick(); dcache_resp_valid = 1'b0;
      checks++; if ({wb_valid, load_data} !== {1'b1, exp}) begin errors++; $display("FAIL %s_data: got %b %h want 1 %h", name, wb_valid, load_data, exp); end
      tick();
   endtask

   task automatic test_extract();
      run_load("lhu", 3'b101, 32'h0000_5002, 32'h80AA_5511, 32'h0000_80AA);
      run_load("lh",  3'b001, 32'h0000_5000, 32'h0000_F00D, 32'hFFFF_F00D);
      run_load("lbu", 3'b100, 32'h0000_5001, 32'h80AA_5511, 32'h0000_0055);
      run_load("lb2", 3'b000, 32'h0000_5002, 32'h807A_5511, 32'h0000_007A);
      run_load("lhs", 3'b001, 32'h0000_5002, 32'h9ABC_1234, 32'hFFFF_9ABC);
   endtask

   task automatic test_timeout();
      present_op(1'b1, 1'b0, 3'b101, 32'h0000_6000, 32'd0, 4'd0);
      tick(); clear_op();
      dcache_req_ready = 1'b1;
      tick(); dcache_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if ({exc_bus, stall} !== 2'b01) begin errors++; $display("FAIL to_wait_%0d: got %b want 01", i, {exc_bus, stall}); end
         tick();
      end
      checks++; if ({exc_bus, stall} !== 2'b01) begin errors++; $display("FAIL to_wait_last: got %b want 01", {exc_bus, stall}); end
      tick();
      checks++; if ({exc_bus, stall, wb_valid} !== 3'b100) begin errors++; $display("FAIL to_exc_bus: got %b want 100", {exc_bus, stall, wb_valid}); end
      checks++; if (load_data !== 32'hFFFF_9ABC) begin errors++; $display("FAIL to_load_hold: got %h want ffff9abc", load_data); end
      tick();
      checks++; if ({exc_bus, stall} !== 2'b00) begin errors++; $display("FAIL to_pulse_end: got %b want 00", {exc_bus, stall}); end
   endtask

   task automatic test_resp_at_timeout();
      present_op(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'd0, 4'd0);
      tick(); clear_op();
      dcache_req_ready = 1'b1;
      tick(); dcache_req_ready = 1'b0;
      tick(); tick(); tick();
      dcache_resp_valid = 1'b1; dcache_dout = 32'hCAFE_F00D;
      tick(); dcache_resp_valid = 1'b0;
      checks++; if ({wb_valid, exc_bus, load_data} !== {2'b10, 32'hCAFE_F00D}) begin errors++; $display("FAIL race_resp_wins: got %b%b %h want 10 cafef00d", wb_valid, exc_bus, load_data); end
      tick();
      checks++; if (exc_bus !== 1'b0) begin errors++; $display("FAIL race_no_exc: got %b want 0", exc_bus); end
   endtask

   task automatic test_reset_mid();
      present_op(1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'd0, 4'd0);
      tick(); clear_op();
      dcache_req_ready = 1'b1;
      tick(); dcache_req_ready = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({stall, wb_valid, exc_bus, exc_misaligned, dcache_req_valid, load_data} !== 37'd0) begin errors++; $display("FAIL rst_mid_outputs: got %b%b%b%b%b %h want all zero", stall, wb_valid, exc_bus, exc_misaligned, dcache_req_valid, load_data); end
      @(negedge clk); reset_n = 1'b1;
      dcache_resp_valid = 1'b1; dcache_dout = 32'h5555_AAAA;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if ({wb_valid, exc_bus, stall, load_data} !== 35'd0) begin errors++; $display("FAIL rst_mid_late_%0d: got %b%b%b %h want 000 00000000", i, wb_valid, exc_bus, stall, load_data); end
      end
      dcache_resp_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      run_load("b2b_a", 3'b010, 32'h0000_9000, 32'h0102_0304, 32'h0102_0304);
      run_load("b2b_b", 3'b100, 32'h0000_9003, 32'hF102_0304, 32'h0000_00F1);
   endtask

   initial begin
      test_reset();
      test_lb();
      test_sh();
      test_sb_lanes();
      test_misaligned();
      test_ignore();
      test_ready_stall();
      test_extract();
      test_timeout();
      test_resp_at_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
